// File: rtl/fw_bxclk_gen_pkg.sv
// Shared types and widths for the multi-channel bunch-crossing clock generator.
// Holds the FSM state enum and the config record used for both the shadow and the active copy.
package fw_bxclk_gen_pkg;

    localparam int N_CH     = 4;
    localparam int PERIOD_W = 6;
    localparam int DELAY_W  = 5;
    localparam int BURST_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [PERIOD_W-1:0]             period;
        logic [N_CH-1:0][DELAY_W-1:0]    delay;
        logic [N_CH-1:0]                 sign;
        logic                            burst_mode;
        logic [BURST_W-1:0]              burst_len;
    } cfg_t;

endpackage

// File: rtl/fw_bxclk_phase_ch.sv
// One delayed/inverted output channel: modular phase offset from the master count,
// half-period compare, polarity flip and a single output register.
module fw_bxclk_phase_ch
    import fw_bxclk_gen_pkg::*;
(
    input  logic                fw_pl_clk1,
    input  logic                fw_rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] cnt,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] half,
    input  logic [DELAY_W-1:0]  delay,
    input  logic                sign,
    output logic                ch_clk
);

    logic [PERIOD_W-1:0] d_ext;
    logic [PERIOD_W-1:0] cnt_i;

    assign d_ext = PERIOD_W'(delay);

    // Delay never exceeds half a period, so one conditional add replaces a modulo.
    always_comb begin
        cnt_i = (cnt >= d_ext) ? (cnt - d_ext) : (cnt + period - d_ext);
    end

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            ch_clk <= 1'b0;
        end else begin
            ch_clk <= en & ((cnt_i < half) ^ sign);
        end
    end

endmodule

// File: rtl/fw_bxclk_gen_multi.sv
// Reference clock plus N_CH phase-shifted copies derived from fw_pl_clk1, with free-run and
// burst modes; configuration is shadowed and only takes effect on a period boundary.
module fw_bxclk_gen_multi
    import fw_bxclk_gen_pkg::*;
(
    input  logic                     fw_pl_clk1,
    input  logic                     fw_rst,
    input  logic                     fw_enable,
    input  logic                     cfg_wr,
    input  logic [PERIOD_W-1:0]      cfg_period,
    input  logic [N_CH*DELAY_W-1:0]  cfg_delay,
    input  logic [N_CH-1:0]          cfg_sign,
    input  logic                     cfg_burst_mode,
    input  logic [BURST_W-1:0]       cfg_burst_len,
    input  logic                     burst_start,
    output logic                     fw_bxclk_ana,
    output logic [N_CH-1:0]          fw_bxclk,
    output logic                     busy,
    output logic                     burst_done,
    output logic                     cfg_err,
    output state_t                   state_dbg
);

    state_t              state, state_nx;
    cfg_t                shadow, active, cfg_cap, cfg_next;
    logic                cap_legal, cap_clamped;
    logic [PERIOD_W-1:0] cnt, half, p_last;
    logic [BURST_W-1:0]  per_cnt, len_last;
    logic                burst_ok;
    logic                wrap, burst_final, start_run, load_active, out_en;

    assign half      = active.period >> 1;
    assign p_last    = active.period - PERIOD_W'(1);
    assign wrap      = (cnt == p_last);
    assign len_last  = (active.burst_len == '0) ? '0 : active.burst_len - BURST_W'(1);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Legalise a capture: short periods are rejected, delays beyond half a period are clamped.
    always_comb begin
        cfg_cap            = '0;
        cap_clamped        = 1'b0;
        cfg_cap.period     = cfg_period;
        cfg_cap.sign       = cfg_sign;
        cfg_cap.burst_mode = cfg_burst_mode;
        cfg_cap.burst_len  = cfg_burst_len;
        for (int i = 0; i < N_CH; i++) begin
            if (PERIOD_W'(cfg_delay[i*DELAY_W +: DELAY_W]) > (cfg_period >> 1)) begin
                cfg_cap.delay[i] = DELAY_W'(cfg_period >> 1);
                cap_clamped      = 1'b1;
            end else begin
                cfg_cap.delay[i] = cfg_delay[i*DELAY_W +: DELAY_W];
            end
        end
        cap_legal = (cfg_period >= PERIOD_W'(2));
        cfg_next  = (cfg_wr && cap_legal) ? cfg_cap : shadow;
    end

    // A write landing on a boundary (or in IDLE) is applied straight away through cfg_next.
    always_comb begin
        state_nx    = state;
        load_active = 1'b0;
        out_en      = 1'b0;
        burst_final = active.burst_mode && (per_cnt >= len_last);
        start_run   = fw_enable && (cfg_next.period >= PERIOD_W'(2)) &&
                      (!cfg_next.burst_mode || burst_start);
        case (state)
            IDLE: begin
                load_active = 1'b1;
                if (start_run) state_nx = RUN;
            end
            RUN: begin
                out_en      = 1'b1;
                load_active = wrap;
                if (!fw_enable || burst_final) state_nx = DRAIN;
            end
            DRAIN: begin
                out_en = !wrap;
                if (wrap) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            per_cnt      <= '0;
            shadow       <= '0;
            active       <= '0;
            cfg_err      <= 1'b0;
            burst_ok     <= 1'b0;
            burst_done   <= 1'b0;
            fw_bxclk_ana <= 1'b0;
        end else begin
            state <= state_nx;
            if (cfg_wr) begin
                if (!cap_legal) begin
                    cfg_err <= 1'b1;
                end else begin
                    shadow  <= cfg_cap;
                    cfg_err <= cap_clamped;
                end
            end
            if (load_active) active <= cfg_next;

            if (state == IDLE || wrap) cnt <= '0;
            else                       cnt <= cnt + PERIOD_W'(1);

            if (state == IDLE)                                 per_cnt <= '0;
            else if (state == RUN && wrap && active.burst_mode) per_cnt <= per_cnt + BURST_W'(1);

            // Only a burst that ran to its final period earns a completion pulse.
            if (state == RUN && state_nx == DRAIN) burst_ok <= fw_enable && burst_final;
            burst_done   <= (state == DRAIN) && wrap && burst_ok;
            fw_bxclk_ana <= out_en && (cnt < half);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        fw_bxclk_phase_ch u_ch (
            .fw_pl_clk1 (fw_pl_clk1),
            .fw_rst     (fw_rst),
            .en         (out_en),
            .cnt        (cnt),
            .period     (active.period),
            .half       (half),
            .delay      (active.delay[g]),
            .sign       (active.sign[g]),
            .ch_clk     (fw_bxclk[g])
        );
    end

endmodule

// File: tb/tb_fw_bxclk_gen_multi.sv
// Bench for fw_bxclk_gen_multi: a tick-based reference model compared every cycle,
// plus directed edge-timing checks with hand-computed distances.
module tb_fw_bxclk_gen_multi;
    import fw_bxclk_gen_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic                    fw_pl_clk1 = 1'b0;
    logic                    fw_rst = 1'b1;
    logic                    fw_enable = 1'b0;
    logic                    cfg_wr = 1'b0;
    logic [PERIOD_W-1:0]     cfg_period = '0;
    logic [N_CH*DELAY_W-1:0] cfg_delay = '0;
    logic [N_CH-1:0]         cfg_sign = '0;
    logic                    cfg_burst_mode = 1'b0;
    logic [BURST_W-1:0]      cfg_burst_len = '0;
    logic                    burst_start = 1'b0;
    logic                    fw_bxclk_ana;
    logic [N_CH-1:0]         fw_bxclk;
    logic                    busy, burst_done, cfg_err;
    state_t                  state_dbg;

    always #5 fw_pl_clk1 = ~fw_pl_clk1;

    fw_bxclk_gen_multi dut (
        .fw_pl_clk1     (fw_pl_clk1),
        .fw_rst         (fw_rst),
        .fw_enable      (fw_enable),
        .cfg_wr         (cfg_wr),
        .cfg_period     (cfg_period),
        .cfg_delay      (cfg_delay),
        .cfg_sign       (cfg_sign),
        .cfg_burst_mode (cfg_burst_mode),
        .cfg_burst_len  (cfg_burst_len),
        .burst_start    (burst_start),
        .fw_bxclk_ana   (fw_bxclk_ana),
        .fw_bxclk       (fw_bxclk),
        .busy           (busy),
        .burst_done     (burst_done),
        .cfg_err        (cfg_err),
        .state_dbg      (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge fw_pl_clk1) cyc++;

    // ---------------- reference model (ticks since run start) ----------------
    int  sh_p, sh_d[N_CH], sh_mode, sh_len;
    bit  sh_s[N_CH];
    int  m_p, m_d[N_CH], m_mode, m_len;
    bit  m_s[N_CH];
    bit  m_run, m_completed, m_last;
    int  m_t, m_pstart, m_nper, m_end, m_k, m_dv;
    bit  e_ana, e_busy, e_done, e_err;
    logic [N_CH-1:0] e_ch;

    function automatic int len_eff(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    task automatic apply_shadow();
        m_p = sh_p; m_mode = sh_mode; m_len = sh_len;
        for (int i = 0; i < N_CH; i++) begin
            m_d[i] = sh_d[i];
            m_s[i] = sh_s[i];
        end
    endtask

    always @(posedge fw_pl_clk1) begin
        if (fw_rst) begin
            sh_p = 0; sh_mode = 0; sh_len = 0;
            for (int i = 0; i < N_CH; i++) begin sh_d[i] = 0; sh_s[i] = 0; end
            apply_shadow();
            m_run = 0; e_ana = 0; e_ch = '0; e_busy = 0; e_done = 0; e_err = 0;
        end else begin
            m_last = m_run && (m_end >= 0) && (m_t == m_end - 1);
            e_ana  = 0;
            e_ch   = '0;
            if (m_run && !m_last) begin
                m_k   = m_t - m_pstart;
                e_ana = (m_k < m_p / 2);
                for (int i = 0; i < N_CH; i++)
                    e_ch[i] = ((((m_k - m_d[i]) % m_p + m_p) % m_p) < m_p / 2) ^ m_s[i];
            end
            e_done = m_last && m_completed;
            if (cfg_wr) begin
                if (int'(cfg_period) < 2) begin
                    e_err = 1;
                end else begin
                    e_err   = 0;
                    sh_p    = int'(cfg_period);
                    sh_mode = int'(cfg_burst_mode);
                    sh_len  = int'(cfg_burst_len);
                    for (int i = 0; i < N_CH; i++) begin
                        m_dv = int'(cfg_delay[i*DELAY_W +: DELAY_W]);
                        if (m_dv > sh_p / 2) begin m_dv = sh_p / 2; e_err = 1; end
                        sh_d[i] = m_dv;
                        sh_s[i] = cfg_sign[i];
                    end
                end
            end
            if (m_last) begin
                m_run = 0;
            end else if (m_run) begin
                if (m_end < 0 && !fw_enable) begin m_end = m_pstart + m_p; m_completed = 0; end
                m_t++;
                if (m_t == m_pstart + m_p) begin
                    m_pstart = m_t;
                    m_nper++;
                    apply_shadow();
                    if (m_mode != 0 && m_nper >= len_eff(m_len) - 1) begin
                        m_end = m_pstart + m_p; m_completed = 1;
                    end
                end
            end else begin
                apply_shadow();
                if (fw_enable && m_p >= 2 && (m_mode == 0 || burst_start)) begin
                    m_run = 1; m_t = 0; m_pstart = 0; m_nper = 0; m_end = -1; m_completed = 0;
                    if (m_mode != 0 && len_eff(m_len) == 1) begin m_end = m_p; m_completed = 1; end
                end
            end
            e_busy = m_run;
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge fw_pl_clk1) begin
        check("ana", int'(fw_bxclk_ana), int'(e_ana));
        check("ch", int'(fw_bxclk), int'(e_ch));
        check("busy", int'(busy), int'(e_busy));
        check("burst_done", int'(burst_done), int'(e_done));
        check("cfg_err", int'(cfg_err), int'(e_err));
    end

    // ---------------- edge monitor ----------------
    int ana_rises = 0, ana_rise_t = 0, ana_fall_t = 0, done_cnt = 0, done_t = 0;
    int ch_rise_t[N_CH], ch_fall_t[N_CH];
    logic prev_ana = 1'b0;
    logic [N_CH-1:0] prev_ch = '0;

    always @(negedge fw_pl_clk1) begin
        if (fw_bxclk_ana && !prev_ana) begin ana_rise_t = cyc; ana_rises++; end
        if (!fw_bxclk_ana && prev_ana) ana_fall_t = cyc;
        for (int i = 0; i < N_CH; i++) begin
            if (fw_bxclk[i] && !prev_ch[i]) ch_rise_t[i] = cyc;
            if (!fw_bxclk[i] && prev_ch[i]) ch_fall_t[i] = cyc;
        end
        if (burst_done) begin done_cnt++; done_t = cyc; end
        prev_ana = fw_bxclk_ana;
        prev_ch  = fw_bxclk;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin @(negedge fw_pl_clk1); #1; end
    endtask

    task automatic do_cfg(input int p, input logic [N_CH*DELAY_W-1:0] d,
                          input logic [N_CH-1:0] s, input bit mode, input int len);
        cfg_period = PERIOD_W'(p); cfg_delay = d; cfg_sign = s;
        cfg_burst_mode = mode; cfg_burst_len = BURST_W'(len);
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_ana_rise(output int t);
        int start, n;
        start = ana_rises;
        n = 0;
        while (ana_rises == start && n < 200) begin step(); n++; end
        if (ana_rises == start) check("ana_rise_timeout", 0, 1);
        t = ana_rise_t;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t0, t1, t2, t3, t4, c, r0, d0, n, p;
        logic [N_CH*DELAY_W-1:0] dv;
        step(4);
        check("rst_ana", int'(fw_bxclk_ana), 0);
        check("rst_ch", int'(fw_bxclk), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(cfg_err), 0);
        fw_rst = 1'b0;
        step(2);

        // P=10, zero delay: every channel tracks ana
        fw_enable = 1'b1;
        do_cfg(10, '0, '0, 0, 0);
        wait_ana_rise(t1);
        wait_ana_rise(t2);
        check("p10_period", t2 - t1, 10);
        check("p10_ch_eq_ana", int'(fw_bxclk), 15);
        step(7);
        check("p10_high", ana_fall_t - t2, 5);

        // P=20, D={0,2,5,10}, S={0,0,1,1}
        do_cfg(20, {5'd10, 5'd5, 5'd2, 5'd0}, 4'b1100, 0, 0);
        wait_ana_rise(t0);
        wait_ana_rise(t0);
        step(15);
        check("p20_ch0_rise", ch_rise_t[0] - t0, 0);
        check("p20_ch1_rise", ch_rise_t[1] - t0, 2);
        check("p20_ch2_fall", ch_fall_t[2] - t0, 5);
        check("p20_ch3_fall", ch_fall_t[3] - t0, 10);

        // odd P=11, then P=14 written mid-period
        do_cfg(11, '0, '0, 0, 0);
        wait_ana_rise(t1);
        wait_ana_rise(t1);
        wait_ana_rise(t2);
        check("p11_period", t2 - t1, 11);
        check("p11_high", ana_fall_t - t1, 5);
        step(3);
        do_cfg(14, '0, '0, 0, 0);
        wait_ana_rise(t3);
        check("p11_finish", t3 - t2, 11);
        wait_ana_rise(t4);
        check("p14_period", t4 - t3, 14);
        check("p14_high", ana_fall_t - t3, 7);

        // illegal period rejected, oversize delay clamped
        do_cfg(20, '0, '0, 0, 0);
        wait_ana_rise(t0);
        do_cfg(1, '0, '0, 0, 0);
        check("p1_err", int'(cfg_err), 1);
        wait_ana_rise(t1);
        wait_ana_rise(t2);
        check("p1_keeps_p20", t2 - t1, 20);
        do_cfg(20, {15'd0, 5'd25}, '0, 0, 0);
        check("clamp_err", int'(cfg_err), 1);
        wait_ana_rise(t0);
        wait_ana_rise(t0);
        step(12);
        check("clamp_ch0_rise", ch_rise_t[0] - t0, 10);
        do_cfg(20, '0, '0, 0, 0);
        check("legal_clears_err", int'(cfg_err), 0);

        // random free-run configurations
        for (int it = 0; it < 50; it++) begin
            p = $urandom_range(10, 40);
            for (int i = 0; i < N_CH; i++) dv[i*DELAY_W +: DELAY_W] = DELAY_W'($urandom_range(0, p / 2));
            do_cfg(p, dv, N_CH'($urandom_range(0, 15)), 0, 0);
            step(3 * p);
        end

        // burst of 3 periods, second burst_start ignored
        wait_ana_rise(t0);
        fw_enable = 1'b0;
        n = 0;
        while (busy && n < 200) begin step(); n++; end
        check("stop_busy", int'(busy), 0);
        do_cfg(10, '0, '0, 1, 3);
        fw_enable = 1'b1;
        step(3);
        check("burst_wait_idle", int'(busy), 0);
        r0 = ana_rises; d0 = done_cnt;
        burst_start = 1'b1; c = cyc;
        step();
        burst_start = 1'b0;
        step(12);
        burst_start = 1'b1;
        step();
        burst_start = 1'b0;
        step(40);
        check("burst_rises", ana_rises - r0, 3);
        check("burst_done_cnt", done_cnt - d0, 1);
        check("burst_done_time", done_t - c, 31);
        check("burst_busy_after", int'(busy), 0);

        // enable dropped at cnt=3: period completes, no done pulse
        do_cfg(10, '0, '0, 0, 0);
        wait_ana_rise(t0);
        step(2);
        fw_enable = 1'b0;
        d0 = done_cnt;
        step(15);
        check("abort_busy", int'(busy), 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_fall", ana_fall_t - t0, 5);
        check("abort_no_rise", ana_rise_t, t0);

        // reset during RUN
        fw_enable = 1'b1;
        wait_ana_rise(t0);
        fw_rst = 1'b1;
        step();
        check("rst_run_ana", int'(fw_bxclk_ana), 0);
        check("rst_run_ch", int'(fw_bxclk), 0);
        check("rst_run_busy", int'(busy), 0);
        fw_rst = 1'b0;
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fw_bxclk_gen_multi.md
Name: fw_bxclk_gen_multi

Overview:
Multi-channel successor to the single bxclk_ana/bxclk generator. From the 400 MHz fw_pl_clk1 it derives:
- one reference clock (ana);
- N_CH phase-shifted copies, each with its own delay and polarity.
Modes are free-running or burst (fixed number of periods). Period, delay, polarity and mode are shadow-registered and applied only at period boundaries, so no runt pulses occur. Sits in the FW IP between the SW op-code decoder and the DUT-side pins.

Parameters:
N_CH, 4, number of delayed output channels
PERIOD_W, 6, width of period field (ticks of fw_pl_clk1)
DELAY_W, 5, width of per-channel delay field
BURST_W, 16, width of burst length counter

Ports:
fw_pl_clk1  in  1  400 MHz clock, sole clock
fw_rst  in  1  synchronous active-high reset
fw_enable  in  1  level; generator allowed to run
cfg_wr  in  1  one-cycle strobe, captures all cfg_* into shadow
cfg_period  in  PERIOD_W  period in ticks
cfg_delay  in  N_CH*DELAY_W  per-channel delay; channel i at bits [i*DELAY_W +: DELAY_W]
cfg_sign  in  N_CH  per-channel polarity (1 = inverted)
cfg_burst_mode  in  1  0 = free-run, 1 = burst
cfg_burst_len  in  BURST_W  periods per burst (0 is treated as 1)
burst_start  in  1  one-cycle strobe, starts a burst
fw_bxclk_ana  out  1  reference clock
fw_bxclk  out  N_CH  delayed/inverted channel clocks
busy  out  1  state != IDLE
burst_done  out  1  one-cycle pulse at end of burst
cfg_err  out  1  sticky; set when a capture was clamped or rejected, cleared by cfg_wr with legal values

Behaviour:
- Reset values: fw_rst=1 clears all outputs to 0, counters to 0, active and shadow config to 0, state to IDLE. Reset mid-run stops all outputs the next cycle, with no completion pulse.
- Master counter cnt runs 0..P-1 (P = active period); half = P>>1.
- Reference clock: fw_bxclk_ana register <= (cnt < half), i.e. high for floor(P/2) ticks, low for P-half ticks.
- Channel i: cnt_i = (cnt - D_i) mod P, computed without a divider as cnt>=D_i ? cnt-D_i : cnt+P-D_i. fw_bxclk[i] register <= (cnt_i < half) XOR S_i.
- Consequences:
  - sign=0: the rising edge of channel i lags the ana rising edge by D_i ticks.
  - sign=1: the falling edge of channel i lags the ana rising edge by D_i ticks.
  - D=0, sign=1: channel is the exact inverse of ana.
- Latency: all outputs are registered once from the same cnt, so relative phases are exact. The first ana rising edge appears 1 cycle after entering RUN.
- Legality at capture:
  - P<2: capture rejected, cfg_err=1, active config unchanged.
  - D_i > half: D_i clamped to half, cfg_err=1.
- Shadow/active config:
  - cfg_wr loads the shadow.
  - Shadow is copied to active when cnt==P-1 in RUN, or immediately in IDLE.
  - cfg_wr and a boundary in the same cycle: the new values are captured and applied at that boundary.
- States:
  - IDLE: outputs forced 0, regardless of sign; cnt=0.
    - -> RUN when fw_enable=1 and active P>=2 and (burst_mode=0, or burst_start=1).
    - burst_start while fw_enable=0 is ignored.
  - RUN: cnt increments and wraps at P-1. In burst mode, per_cnt increments on each wrap.
    - -> DRAIN when fw_enable falls.
    - -> DRAIN when burst mode reaches its final wrap (per_cnt == len-1).
  - DRAIN: the current period finishes; at cnt==P-1 outputs are forced 0.
    - -> IDLE.
    - burst_done pulses for one cycle on that transition, only if the burst completed (not if aborted by enable).
- burst_start in RUN/DRAIN is ignored.
- cfg_wr and burst_start in the same cycle in IDLE: the new config is used for the burst.
- Enable re-asserted during DRAIN: DRAIN still completes to IDLE. The generator restarts from IDLE on the next cycle (free-run).

Decomposition:
- Package fw_bxclk_gen_pkg: state enum (IDLE, RUN, DRAIN), config struct (period, delay array, sign, mode, len), width constants.
- Sub-module fw_bxclk_phase_ch, instantiated N_CH times via generate: modular subtract, compare, XOR sign, output register.
- Top module: counter, FSM, shadow registers, burst counter.

Test Plan:
1. P=10, all D=0, S=0, free-run, enable -> ana period 25.0 ns, high 12.5 ns; every channel identical to ana.
2. P=20, D={0,2,5,10}, S={0,0,1,1} -> ch0 in phase with ana; ch1 rising edge +5.0 ns; ch2 falling edge +12.5 ns; ch3 falling edge +25.0 ns after ana rising edge.
3. P=11 odd -> ana high 5 ticks, low 6 ticks. cfg_wr mid-period with P=14 -> first 14-tick period starts exactly after the current 11-tick period ends; no pulse shorter than 5 ticks.
4. Burst mode, len=3, P=10, burst_start -> exactly 3 ana rising edges, burst_done 1 cycle after the 30th tick, busy 0 afterwards. Second burst_start during RUN is ignored (still 3 edges).
5. Drop fw_enable at cnt=3 of a P=10 period -> remaining ticks complete, then all outputs 0; burst_done stays 0. Random P∈[10,40], D≤P/2, S random, 50 iterations, checked against the period/delay equations.
6. cfg P=1 -> cfg_err=1, previous P retained. D=25 with P=20 -> D clamped to 10, cfg_err=1. fw_rst asserted mid-RUN -> all outputs 0 on the next edge.
